// File: rtl/multi_edge_detector.sv
// Multi-channel synchronised, debounced edge detector with sticky W1C pending/missed flags and OR'd irq.
// Latency: SYNC_STAGES+FILT_CYCLES edges from a_i change to pulse; no backpressure. Optional MULTI_EDGE_MISSED_EN builds missed_o tracking.
module multi_edge_detector #(
    parameter int CH          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CH-1:0]   a_i,
    input  logic [2*CH-1:0] mode_i,
    input  logic [CH-1:0]   clr_i,
    output logic [CH-1:0]   rising_o,
    output logic [CH-1:0]   falling_o,
    output logic [CH-1:0]   pending_o,
    output logic [CH-1:0]   missed_o,
    output logic            irq_o
);
    localparam int CW = $clog2(FILT_CYCLES + 1);

    logic [CH-1:0] sync_q [SYNC_STAGES];
    logic [CH-1:0] s;
    logic [CH-1:0] filt;
    logic [CW-1:0] cnt     [CH];
    logic [CW-1:0] cnt_nxt [CH];
    logic [CH-1:0] toggle;
    logic [CH-1:0] rise_nxt;
    logic [CH-1:0] fall_nxt;
    logic [CH-1:0] en_edge;

    // Reset preloads every stage with the live input so release never shows an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= a_i;
        end else begin
            sync_q[0] <= a_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        toggle   = '0;
        rise_nxt = '0;
        fall_nxt = '0;
        en_edge  = '0;
        for (int i = 0; i < CH; i++) begin
            cnt_nxt[i] = '0;
            if (s[i] != filt[i]) begin
                if (cnt[i] == CW'(FILT_CYCLES - 1)) toggle[i] = 1'b1;
                else                                cnt_nxt[i] = cnt[i] + CW'(1);
            end
            rise_nxt[i] = toggle[i] & ~filt[i];
            fall_nxt[i] = toggle[i] &  filt[i];
            en_edge[i]  = (rise_nxt[i] & mode_i[2*i]) | (fall_nxt[i] & mode_i[2*i+1]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt      <= sync_q[SYNC_STAGES-1] & '0 | a_i;
            rising_o  <= '0;
            falling_o <= '0;
            pending_o <= '0;
            for (int i = 0; i < CH; i++) cnt[i] <= '0;
        end else begin
            filt      <= filt ^ toggle;
            rising_o  <= rise_nxt;
            falling_o <= fall_nxt;
            // A new enabled edge outranks a same-cycle clear.
            pending_o <= en_edge | (pending_o & ~clr_i);
            for (int i = 0; i < CH; i++) cnt[i] <= cnt_nxt[i];
        end
    end

`ifdef MULTI_EDGE_MISSED_EN
    logic [CH-1:0] missed_q;

    always_ff @(posedge clk) begin
        if (reset) missed_q <= '0;
        else       missed_q <= (en_edge & pending_o & ~clr_i) | (missed_q & ~clr_i);
    end

    assign missed_o = missed_q;
`else
    assign missed_o = '0;
`endif

    assign irq_o = |pending_o;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector at default parameters; missed_o expectations follow MULTI_EDGE_MISSED_EN.
module tb_multi_edge_detector;
    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a_i;
    logic [15:0] mode_i;
    logic [7:0]  clr_i;
    logic [7:0]  rising_o, falling_o, pending_o, missed_o;
    logic        irq_o;

    int n_checks = 0;
    int n_pass   = 0;
    int rise_cnt [8];
    int fall_cnt [8];

`ifdef MULTI_EDGE_MISSED_EN
    localparam logic MISSED_ON = 1'b1;
`else
    localparam logic MISSED_ON = 1'b0;
`endif

    multi_edge_detector dut (
        .clk       (clk),
        .reset     (reset),
        .a_i       (a_i),
        .mode_i    (mode_i),
        .clr_i     (clr_i),
        .rising_o  (rising_o),
        .falling_o (falling_o),
        .pending_o (pending_o),
        .missed_o  (missed_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are read 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            if (rising_o[i])  rise_cnt[i]++;
            if (falling_o[i]) fall_cnt[i]++;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic clear_cnts();
        for (int i = 0; i < 8; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    endtask

    task automatic do_reset(input logic [7:0] level);
        a_i = level; reset = 1'b1;
        run(2);
        reset = 1'b0;
        clear_cnts();
    endtask

    initial begin
        int tot;
        mode_i = '0; clr_i = '0; a_i = '0; reset = 1'b1;

        // Reset with all inputs high, then hold: silence for 20 cycles.
        do_reset(8'hFF);
        check("rst_rising",  32'(rising_o),  32'h0);
        check("rst_pending", 32'(pending_o), 32'h0);
        check("rst_irq",     32'(irq_o),     32'h0);
        run(20);
        tot = 0;
        for (int i = 0; i < 8; i++) tot += rise_cnt[i] + fall_cnt[i];
        check("rst_quiet_pulses", 32'(tot), 32'h0);
        check("rst_quiet_missed", 32'(missed_o), 32'h0);

        // ch0 rise, mode 01: pulse visible after the 6th edge only.
        do_reset(8'h00);
        mode_i[1:0] = 2'b01;
        a_i[0] = 1'b1;
        run(5);
        check("ch0_early", 32'(rise_cnt[0]), 32'h0);
        tick();
        check("ch0_rise_e6", 32'(rising_o), 32'h01);
        check("ch0_pend_e6", 32'(pending_o), 32'h01);
        check("ch0_irq_e6",  32'(irq_o), 32'h1);
        tick();
        check("ch0_rise_e7", 32'(rising_o), 32'h00);
        check("ch0_pend_e7", 32'(pending_o), 32'h01);
        clr_i[0] = 1'b1; tick(); clr_i[0] = 1'b0;
        check("ch0_cleared", 32'(pending_o), 32'h00);
        check("ch0_irq_low", 32'(irq_o), 32'h0);

        // ch1: 3-cycle glitch is discarded, 4-cycle high gives one rise and one fall.
        mode_i[3:2] = 2'b01;
        clear_cnts();
        a_i[1] = 1'b1; run(3); a_i[1] = 1'b0;
        run(12);
        check("ch1_glitch_rise", 32'(rise_cnt[1]), 32'h0);
        check("ch1_glitch_pend", 32'(pending_o[1]), 32'h0);
        a_i[1] = 1'b1; run(4); a_i[1] = 1'b0;
        run(16);
        check("ch1_4cyc_rise", 32'(rise_cnt[1]), 32'h1);
        check("ch1_4cyc_fall", 32'(fall_cnt[1]), 32'h1);
        check("ch1_4cyc_pend", 32'(pending_o[1]), 32'h1);
        clr_i[1] = 1'b1; tick(); clr_i[1] = 1'b0;

        // ch2, mode 10: only the falling edge sets pending; clear loses to a coincident set.
        mode_i[5:4] = 2'b10;
        clear_cnts();
        a_i[2] = 1'b1; run(10);
        check("ch2_rise_cnt", 32'(rise_cnt[2]), 32'h1);
        check("ch2_pend_after_rise", 32'(pending_o[2]), 32'h0);
        a_i[2] = 1'b0; run(10);
        check("ch2_fall_cnt", 32'(fall_cnt[2]), 32'h1);
        check("ch2_pend_after_fall", 32'(pending_o[2]), 32'h1);
        a_i[2] = 1'b1; run(10);
        a_i[2] = 1'b0; run(5);
        clr_i[2] = 1'b1; tick(); clr_i[2] = 1'b0;
        check("ch2_fall_with_clr", 32'(falling_o), 32'h04);
        check("ch2_set_beats_clr", 32'(pending_o[2]), 32'h1);
        check("ch2_no_missed_on_clr", 32'(missed_o[2]), 32'h0);
        clr_i[2] = 1'b1; tick(); clr_i[2] = 1'b0;
        check("ch2_cleared", 32'(pending_o), 32'h00);

        // ch3, mode 11: two edges without clear mark missed (when built).
        mode_i[7:6] = 2'b11;
        a_i[3] = 1'b1; run(10);
        check("ch3_pend_1st", 32'(pending_o[3]), 32'h1);
        check("ch3_missed_1st", 32'(missed_o[3]), 32'h0);
        a_i[3] = 1'b0; run(10);
        check("ch3_missed_2nd", 32'(missed_o), 32'(MISSED_ON) << 3);
        check("ch3_irq", 32'(irq_o), 32'h1);
        clr_i[3] = 1'b1; tick(); clr_i[3] = 1'b0;
        check("ch3_pend_clr", 32'(pending_o), 32'h00);
        check("ch3_missed_clr", 32'(missed_o), 32'h00);
        check("ch3_irq_drop", 32'(irq_o), 32'h0);

        // ch4, mode 00: pulses still appear but nothing latches.
        clear_cnts();
        a_i[4] = 1'b1; run(10); a_i[4] = 1'b0; run(10);
        check("ch4_off_rise", 32'(rise_cnt[4]), 32'h1);
        check("ch4_off_fall", 32'(fall_cnt[4]), 32'h1);
        check("ch4_off_pend", 32'(pending_o), 32'h00);

        // ch5: reset mid-filter absorbs the level change without a pulse.
        mode_i[11:10] = 2'b11;
        a_i[5] = 1'b1; run(4);
        reset = 1'b1; tick(); reset = 1'b0;
        clear_cnts();
        run(12);
        check("ch5_rst_mid_rise", 32'(rise_cnt[5]), 32'h0);
        check("ch5_rst_mid_pend", 32'(pending_o), 32'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
